// File: rtl/rca_pkg.sv
// Shared definitions for the wide adder sequencer: slice width, FSM states,
// and an index-width helper.
package rca_pkg;

  localparam int unsigned SLICE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rca_16bits.sv
// Combinational 16-bit ripple-carry adder slice.
module rca_16bits (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        cin,
  output logic [15:0] out,
  output logic        cout
);

  logic [16:0] carry;

  always_comb begin
    carry    = '0;
    out      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < 16; i++) begin
      out[i]     = in1[i] ^ in2[i] ^ carry[i];
      carry[i+1] = (in1[i] & in2[i]) | (carry[i] & (in1[i] ^ in2[i]));
    end
    cout = carry[16];
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: time-multiplexes one 16-bit ripple slice across
// NSLICES operand slices, with valid/ready on both sides.
module wide_add_sequencer
  import rca_pkg::*;
#(
  parameter int unsigned NSLICES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SLICE_W*NSLICES-1:0]   a,
  input  logic [SLICE_W*NSLICES-1:0]   b,
  input  logic                         cin,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SLICE_W*NSLICES-1:0]   sum,
  output logic                         cout
);

  localparam int unsigned W     = SLICE_W * NSLICES;
  localparam int unsigned IDX_W = (clog2(NSLICES) == 0) ? 1 : clog2(NSLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
  logic               slice_cout;

  assign slice_a = a_q[SLICE_W*idx_q +: SLICE_W];
  assign slice_b = b_q[SLICE_W*idx_q +: SLICE_W];

  rca_16bits u_rca (
    .in1  (slice_a),
    .in2  (slice_b),
    .cin  (c_q),
    .out  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    c_d         = c_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[SLICE_W*idx_q +: SLICE_W] = slice_sum;
        c_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          // Explicit wrap keeps idx in range for non-power-of-two NSLICES.
          idx_d       = '0;
          cout_d      = slice_cout;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      c_q         <= c_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomized self-checking bench for wide_add_sequencer against an
// arithmetic reference model.
module tb_wide_add_sequencer;

  localparam int unsigned NS = 4;
  localparam int unsigned W  = 16 * NS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.NSLICES(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic [W-1:0] rand_w();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction; out_ready held low for 'hold' DONE cycles while
  // in_valid is pulsed with junk operands that must be ignored.
  task automatic run_txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         input int unsigned hold, input string tag);
    logic [W:0]  exp;
    int unsigned lat;
    exp       = model(x, y, ci);
    out_ready = 1'b0;
    check({tag, "_ready_idle"}, in_ready, 1);
    a = x; b = y; cin = ci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_ready_run"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, NS);
    check({tag, "_result"}, {cout, sum}, exp);
    for (int unsigned i = 0; i < hold; i++) begin
      a = rand_w(); b = rand_w(); cin = $urandom_range(0, 1);
      in_valid = (i % 2 == 0);
      tick();
      check({tag, "_hold_result"}, {cout, sum}, exp);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_release_valid"}, out_valid, 0);
    check({tag, "_release_ready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] exp_q[$];
    logic [W:0] exp;
    int         last;
    int unsigned got, pushed, cyc;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", {cout, sum}, 0);
    @(negedge clk) rst = 1'b1;

    run_txn(64'd1117, 64'd232, 1'b0, 0, "basic");
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, "ripple");
    run_txn(64'h0000_FFFF_0000_FFFF, 64'd0, 1'b1, 0, "cin_chain");
    run_txn(rand_w(), rand_w(), 1'b1, 5, "backpressure");

    for (int unsigned i = 0; i < 8; i++)
      run_txn(rand_w(), rand_w(), 1'(($urandom % 2)), $urandom_range(0, 3), "rand");

    // Reset during the RUN cycle with idx = 2 (two slices already written).
    a = 64'h1111_2222_3333_4444; b = 64'h0101_0202_0303_0404; cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("midrun_partial_nonzero", (sum != '0), 1);
    rst = 1'b0;
    #1;
    check("midrun_rst_valid", out_valid, 0);
    check("midrun_rst_result", {cout, sum}, 0);
    check("midrun_rst_ready", in_ready, 1);
    in_valid = 1'b1; a = rand_w(); b = rand_w();
    tick();
    tick();
    check("midrun_rst_ignore_valid", out_valid, 0);
    check("midrun_rst_ignore_ready", in_ready, 1);
    check("midrun_rst_ignore_result", {cout, sum}, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    run_txn(64'd12, 64'd10, 1'b1, 0, "post_rst");
    check("post_rst_value", {cout, sum}, 65'd23);

    // Back-to-back stream with in_valid and out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    got = 0; pushed = 0; cyc = 0; last = -1;
    while (got < 12 && cyc < 400) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b_unexpected_result", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check("b2b_result", {cout, sum}, exp);
        end
        if (last >= 0) check("b2b_interval", cyc - last, NS + 2);
        last = cyc;
        got++;
      end
      a = rand_w(); b = rand_w(); cin = 1'($urandom % 2);
      if (in_ready) begin
        if (pushed < 12) begin
          exp_q.push_back(model(a, b, cin));
          pushed++;
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b_count", got, 12);
    check("b2b_leftover", exp_q.size(), 0);
    for (int unsigned i = 0; i < 2 * (NS + 2); i++) begin
      tick();
      check("b2b_no_extra", out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
